// File: rtl/csr_access_unit_pkg.sv
// rtl/csr_access_unit_pkg.sv - shared widths, CSR addresses, op codes and FSM states
package csr_access_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] MSTATUS_A = 12'h300;
  localparam logic [11:0] MTVEC_A   = 12'h305;
  localparam logic [11:0] MEPC_A    = 12'h341;
  localparam logic [11:0] MCAUSE_A  = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

  typedef enum logic [2:0] {
    OP_RW    = 3'd1,
    OP_RS    = 3'd2,
    OP_RC    = 3'd3,
    OP_ECALL = 3'd4,
    OP_MRET  = 3'd5
  } csr_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_T_EPC,
    S_T_CAUSE,
    S_T_VEC,
    S_RET,
    S_DONE
  } state_e;

  function automatic logic is_csr_op(input logic [2:0] op);
    return (op == OP_RW) || (op == OP_RS) || (op == OP_RC);
  endfunction

  function automatic logic is_trap_op(input logic [2:0] op);
    return (op == OP_ECALL) || (op == OP_MRET);
  endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// rtl/csr_access_unit_if.sv - request/response handshake between execute stage and CSR unit
interface csr_access_unit_if;
  import csr_access_unit_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_op;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            req_nowrite;
  logic [XLEN-1:0] req_pc;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_nowrite, req_pc,
    input  req_ready, resp_valid, resp_rdata, resp_illegal, redirect_valid, redirect_pc
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_nowrite, req_pc,
    output req_ready, resp_valid, resp_rdata, resp_illegal, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/csr_access_unit_alu.sv
// rtl/csr_access_unit_alu.sv - combinational new-value computation for CSRRW/CSRRS/CSRRC
module csr_alu
  import csr_access_unit_pkg::*;
(
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] new_o
);

  always_comb begin
    new_o = wdata_i;
    case (op_i)
      OP_RW:   new_o = wdata_i;
      OP_RS:   new_o = old_i | wdata_i;
      OP_RC:   new_o = old_i & ~wdata_i;
      default: new_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// rtl/csr_access_unit.sv - CSR read/modify/write, ECALL trap entry and MRET sequencer
// Optional: CSR_ACCESS_CHECK_EN blocks writes to read-only CSRs (addr[11:10] == 2'b11).
module csr_access_unit
  import csr_access_unit_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  csr_access_unit_if.slave    bus_if,
  output logic [11:0]         csr_addr_r_o,
  input  logic [XLEN-1:0]     csr_data_r_i,
  output logic [11:0]         csr_addr_w_o,
  output logic [XLEN-1:0]     csr_data_w_o,
  output logic                csr_we_o
);

`ifdef CSR_ACCESS_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            nowrite_q, nowrite_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic            illegal_q, illegal_d;

  logic            req_ready;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_illegal;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            write_req;
  logic            blocked;
  logic [XLEN-1:0] alu_new;

  csr_alu u_alu (
    .op_i    (op_q),
    .old_i   (old_q),
    .wdata_i (wdata_q),
    .new_o   (alu_new)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      nowrite_q <= 1'b0;
      pc_q      <= '0;
      old_q     <= '0;
      redir_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      nowrite_q <= nowrite_d;
      pc_q      <= pc_d;
      old_q     <= old_d;
      redir_q   <= redir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    nowrite_d      = nowrite_q;
    pc_d           = pc_q;
    old_d          = old_q;
    redir_d        = redir_q;
    illegal_d      = illegal_q;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_illegal   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    csr_addr_r_o   = '0;
    csr_addr_w_o   = '0;
    csr_data_w_o   = '0;
    csr_we_o       = 1'b0;
    write_req      = 1'b0;
    blocked        = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (bus_if.req_valid) begin
          op_d      = bus_if.req_op;
          addr_d    = bus_if.req_addr;
          wdata_d   = bus_if.req_wdata;
          nowrite_d = bus_if.req_nowrite;
          pc_d      = bus_if.req_pc;
          old_d     = '0;
          redir_d   = '0;
          illegal_d = 1'b0;
          case (bus_if.req_op)
            OP_RW, OP_RS, OP_RC: state_d = S_RD;
            OP_ECALL:            state_d = S_T_EPC;
            OP_MRET:             state_d = S_RET;
            default: begin
              illegal_d = 1'b1;
              state_d   = S_DONE;
            end
          endcase
        end
      end

      S_RD: begin
        csr_addr_r_o = addr_q;
        old_d        = csr_data_r_i;
        state_d      = S_WR;
      end

      // nowrite only suppresses set/clear; CSRRW always writes.
      S_WR: begin
        write_req = (op_q == OP_RW) || !nowrite_q;
        blocked   = CHECK_EN && (addr_q[11:10] == 2'b11) && write_req;
        if (write_req && !blocked) begin
          csr_we_o     = 1'b1;
          csr_addr_w_o = addr_q;
          csr_data_w_o = alu_new;
        end
        illegal_d = blocked;
        state_d   = S_DONE;
      end

      S_T_EPC: begin
        csr_we_o     = 1'b1;
        csr_addr_w_o = MEPC_A;
        csr_data_w_o = pc_q;
        state_d      = S_T_CAUSE;
      end

      S_T_CAUSE: begin
        csr_we_o     = 1'b1;
        csr_addr_w_o = MCAUSE_A;
        csr_data_w_o = CAUSE_ECALL;
        state_d      = S_T_VEC;
      end

      S_T_VEC: begin
        csr_addr_r_o = MTVEC_A;
        redir_d      = {csr_data_r_i[XLEN-1:2], 2'b00};
        state_d      = S_DONE;
      end

      S_RET: begin
        csr_addr_r_o = MEPC_A;
        redir_d      = csr_data_r_i;
        state_d      = S_DONE;
      end

      S_DONE: begin
        resp_valid     = 1'b1;
        resp_rdata     = is_csr_op(op_q) ? old_q : '0;
        resp_illegal   = illegal_q;
        redirect_valid = is_trap_op(op_q);
        redirect_pc    = is_trap_op(op_q) ? redir_q : '0;
        state_d        = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus_if.req_ready      = req_ready;
  assign bus_if.resp_valid     = resp_valid;
  assign bus_if.resp_rdata     = resp_rdata;
  assign bus_if.resp_illegal   = resp_illegal;
  assign bus_if.redirect_valid = redirect_valid;
  assign bus_if.redirect_pc    = redirect_pc;

endmodule
